// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a small transmit FIFO.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 51,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        baud_tick_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bit;
    logic [BW-1:0]        r_baud;
    logic                 w_push, w_pop, w_tick, w_last_stop;
    logic [DATA_BITS-1:0] w_head;

    assign tx_ready    = fifo_count != (AW+1)'(FIFO_DEPTH);
    assign w_push      = tx_valid && tx_ready;
    assign w_tick      = r_state != S_IDLE && r_baud == BW'(CLKS_PER_BIT - 1);
    assign w_last_stop = r_state == S_STOP && w_tick && r_bit == 4'(STOP_BITS);
    // Pops happen only when a frame begins: from idle, or on the last stop tick.
    assign w_pop       = fifo_count != '0 && (r_state == S_IDLE || w_last_stop);
    assign w_head      = r_mem[r_rd_ptr];
    assign busy        = r_state != S_IDLE;
    assign baud_tick_o = w_tick;

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr_ptr] <= tx_data;

`ifdef UART_TX_PARITY_EN
    logic r_par;
    always_ff @(posedge clk)
        if (w_pop) r_par <= (PARITY_ODD != 0) ? ~^w_head : ^w_head;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            tx         <= 1'b1;
            fifo_count <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_shift    <= '0;
            r_bit      <= '0;
            r_baud     <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_baud     <= (r_state == S_IDLE || w_tick) ? '0 : r_baud + 1'b1;
            if (w_pop) begin
                r_shift <= w_head;
                tx      <= 1'b0;
                r_state <= S_START;
            end else if (w_tick) begin
                case (r_state)
                    S_START: begin
                        tx      <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= 4'd1;
                        r_state <= S_DATA;
                    end
                    S_DATA: begin
                        if (r_bit == 4'(DATA_BITS)) begin
`ifdef UART_TX_PARITY_EN
                            tx      <= r_par;
                            r_state <= S_PARITY;
`else
                            tx      <= 1'b1;
                            r_state <= S_STOP;
`endif
                            r_bit   <= 4'd1;
                        end else begin
                            tx      <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_bit   <= r_bit + 4'd1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: begin
                        tx      <= 1'b1;
                        r_bit   <= 4'd1;
                        r_state <= S_STOP;
                    end
`endif
                    S_STOP: begin
                        if (r_bit == 4'(STOP_BITS)) r_state <= S_IDLE;
                        else r_bit <= r_bit + 4'd1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios against an 8N1 instance and a 7-data/2-stop instance.
module tb_uart_tx_fifo;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL_A = (1 + 8 + P + 1) * C;
    localparam int FL_B = (1 + 7 + P + 2) * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data_a = '0;
    logic       tx_valid_a = 1'b0;
    logic       tx_ready_a, tx_a, busy_a, tick_a;
    logic [2:0] cnt_a;
    logic [6:0] tx_data_b = '0;
    logic       tx_valid_b = 1'b0;
    logic       tx_ready_b, tx_b, busy_b, tick_b;
    logic [2:0] cnt_b;

    int checks = 0;
    int failures = 0;
    logic qa[$], qab[$], qt[$], qb[$], qbb[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a), .baud_tick_o(tick_a));

    uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b), .baud_tick_o(tick_b));

    // Expected line level for bit period b of a frame carrying d (nd data bits).
    function automatic logic exp_bit(logic [8:0] d, int nd, int b);
        logic [8:0] m;
        m = d & ((9'd1 << nd) - 9'd1);
        if (b == 0) return 1'b0;
        if (b <= nd) return m[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == nd + 1) return ^m;
`endif
        return 1'b1;
    endfunction

    task automatic step();
        @(negedge clk);
        qa.push_back(tx_a);
        qab.push_back(busy_a);
        qt.push_back(tick_a);
        qb.push_back(tx_b);
        qbb.push_back(busy_b);
    endtask

    task automatic clear_q();
        qa.delete(); qab.delete(); qt.delete(); qb.delete(); qbb.delete();
    endtask

    task automatic do_reset();
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clear_q();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx_a); end
        checks++; if (tx_ready_a !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", tx_ready_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        checks++; if (cnt_a !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt_a); end
        checks++; if (tick_a !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick_a); end
        checks++; if (tx_b !== 1'b1) begin failures++; $display("FAIL reset_tx_b got=%b exp=1", tx_b); end
    endtask

    task automatic test_single();
        int errs, ticks;
        do_reset();
        tx_data_a = 8'hA5;
        tx_valid_a = 1'b1;
        step();
        tx_valid_a = 1'b0;
        tx_data_a = 8'hFF;
        checks++; if (cnt_a !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", cnt_a); end
        checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL single_pre_start got=%b exp=1", tx_a); end
        clear_q();
        repeat (FL_A) step();
        errs = 0;
        ticks = 0;
        for (int k = 0; k < FL_A; k++) begin
            if (qa[k] !== exp_bit({1'b0, 8'hA5}, 8, k / C)) errs++;
            if (qt[k] === 1'b1) ticks++;
        end
        checks++; if (qa[0] !== 1'b0) begin failures++; $display("FAIL single_start_latency got=%b exp=0", qa[0]); end
        checks++; if (errs != 0) begin failures++; $display("FAIL single_frame bad_cycles got=%0d exp=0", errs); end
        checks++; if (ticks != FL_A / C) begin failures++; $display("FAIL single_ticks got=%0d exp=%0d", ticks, FL_A / C); end
        step();
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", busy_a); end
        checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL single_idle_tx got=%b exp=1", tx_a); end
    endtask

    task automatic test_burst();
        int acc, errs, f;
        do_reset();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            tx_data_a = 8'(i + 1);
            tx_valid_a = 1'b1;
            if (tx_ready_a) acc++;
            step();
        end
        tx_valid_a = 1'b0;
        checks++; if (acc != 5) begin failures++; $display("FAIL burst_accepted got=%0d exp=5", acc); end
        checks++; if (cnt_a !== 3'd4) begin failures++; $display("FAIL burst_count got=%0d exp=4", cnt_a); end
        checks++; if (tx_ready_a !== 1'b0) begin failures++; $display("FAIL burst_ready got=%b exp=0", tx_ready_a); end
        repeat (5 * FL_A + 4) step();
        f = -1;
        for (int k = 0; k < qa.size() && f < 0; k++) if (qa[k] === 1'b0) f = k;
        checks++; if (f != 1) begin failures++; $display("FAIL burst_first_start got=%0d exp=1", f); end
        errs = 0;
        for (int k = 0; k < 5 * FL_A; k++)
            if (qa[1 + k] !== exp_bit(9'(k / FL_A + 1), 8, (k % FL_A) / C)) errs++;
        checks++; if (errs != 0) begin failures++; $display("FAIL burst_frames bad_cycles got=%0d exp=0", errs); end
        checks++; if (qa[1 + 5 * FL_A] !== 1'b1) begin failures++; $display("FAIL burst_tail got=%b exp=1", qa[1 + 5 * FL_A]); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL burst_busy_end got=%b exp=0", busy_a); end
    endtask

    task automatic test_stop2();
        int errs, nbusy;
        do_reset();
        tx_data_b = 7'h55;
        tx_valid_b = 1'b1;
        step();
        tx_data_b = 7'h2A;
        step();
        tx_valid_b = 1'b0;
        repeat (2 * FL_B + 4) step();
        errs = 0;
        nbusy = 0;
        for (int k = 0; k < 2 * FL_B; k++)
            if (qb[1 + k] !== exp_bit((k < FL_B) ? 9'h55 : 9'h2A, 7, (k % FL_B) / C)) errs++;
        for (int k = 0; k < qbb.size(); k++) if (qbb[k] === 1'b1) nbusy++;
        checks++; if (errs != 0) begin failures++; $display("FAIL stop2_frames bad_cycles got=%0d exp=0", errs); end
        checks++; if (nbusy != 2 * FL_B) begin failures++; $display("FAIL stop2_busy_cycles got=%0d exp=%0d", nbusy, 2 * FL_B); end
        checks++; if (qb[FL_B] !== 1'b1) begin failures++; $display("FAIL stop2_last_stop got=%b exp=1", qb[FL_B]); end
        checks++; if (qb[1 + FL_B] !== 1'b0) begin failures++; $display("FAIL stop2_next_start got=%b exp=0", qb[1 + FL_B]); end
    endtask

    task automatic test_reset_mid();
        int lows, nbusy;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tx_data_a = 8'(8'h11 * (i + 1));
            tx_valid_a = 1'b1;
            step();
        end
        tx_valid_a = 1'b0;
        checks++; if (cnt_a !== 3'd2) begin failures++; $display("FAIL rmid_queued got=%0d exp=2", cnt_a); end
        repeat (12) step();
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL rmid_busy_before got=%b exp=1", busy_a); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL rmid_tx got=%b exp=1", tx_a); end
        checks++; if (cnt_a !== 3'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", cnt_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy_a); end
        checks++; if (tx_ready_a !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", tx_ready_a); end
        clear_q();
        repeat (3 * FL_A) step();
        lows = 0;
        nbusy = 0;
        for (int k = 0; k < qa.size(); k++) begin
            if (qa[k] !== 1'b1) lows++;
            if (qab[k] !== 1'b0) nbusy++;
        end
        checks++; if (lows != 0) begin failures++; $display("FAIL rmid_no_frame low_cycles got=%0d exp=0", lows); end
        checks++; if (nbusy != 0) begin failures++; $display("FAIL rmid_stay_idle busy_cycles got=%0d exp=0", nbusy); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tx_data_a = 8'(i + 1);
            tx_valid_a = 1'b1;
            step();
        end
        tx_valid_a = 1'b0;
        checks++; if (cnt_a !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", cnt_a); end
        repeat (FL_A - 4) step();
        checks++; if (tick_a !== 1'b1) begin failures++; $display("FAIL full_final_tick got=%b exp=1", tick_a); end
        checks++; if (tx_ready_a !== 1'b0) begin failures++; $display("FAIL full_ready_at_pop got=%b exp=0", tx_ready_a); end
        tx_data_a = 8'h77;
        tx_valid_a = 1'b1;
        step();
        tx_valid_a = 1'b0;
        checks++; if (cnt_a !== 3'd3) begin failures++; $display("FAIL full_count_after got=%0d exp=3", cnt_a); end
        checks++; if (tx_ready_a !== 1'b1) begin failures++; $display("FAIL full_ready_after got=%b exp=1", tx_ready_a); end
        checks++; if (tx_a !== 1'b0) begin failures++; $display("FAIL full_next_start got=%b exp=0", tx_a); end
        repeat (4 * FL_A + 4) step();
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL full_drained_busy got=%b exp=0", busy_a); end
        checks++; if (cnt_a !== 3'd0) begin failures++; $display("FAIL full_drained_count got=%0d exp=0", cnt_a); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        do_reset();
        tx_data_a = 8'h07;
        tx_valid_a = 1'b1;
        step();
        tx_valid_a = 1'b0;
        clear_q();
        repeat (FL_A + 1) step();
        checks++; if (qa[8 * C] !== 1'b0) begin failures++; $display("FAIL parity_msb got=%b exp=0", qa[8 * C]); end
        checks++; if (qa[9 * C] !== 1'b1) begin failures++; $display("FAIL parity_bit got=%b exp=1", qa[9 * C]); end
        checks++; if (qab[FL_A - 1] !== 1'b1 || qab[FL_A] !== 1'b0) begin
            failures++; $display("FAIL parity_len busy_end got=%b%b exp=10", qab[FL_A - 1], qab[FL_A]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_stop2();
        test_reset_mid();
        test_full_pop();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It adds a configurable baud divisor, data width and stop-bit count, and a small transmit FIFO so that frames go out back to back with no idle gap. It sits between the host-side valid/ready byte stream and the serial tx pin. Its bit timing is exact from the start of each frame.

Parameters:
CLKS_PER_BIT, 51, clock cycles per bit period; must be >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
FIFO_DEPTH, 4, transmit FIFO entries; power of two, >= 2.
PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only with UART_TX_PARITY_EN.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
tx_data  input  DATA_BITS  word to transmit
tx_valid  input  1  host offers tx_data
tx_ready  output  1  FIFO not full; a word is accepted on a rising edge where tx_valid && tx_ready
tx  output  1  UART serial line; idles high
busy  output  1  a frame is in progress (state != IDLE)
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words held in the FIFO
baud_tick_o  output  1  one-cycle pulse on the last clock of each bit period; 0 in IDLE

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - tx=1, tx_ready=1, busy=0, fifo_count=0, baud_tick_o=0.
  - FIFO is flushed, state = IDLE, bit counter and baud counter = 0.
  - Reset mid-frame aborts the frame. tx is high from the next edge, and the aborted word is not resent.
- FIFO:
  - Synchronous, first-word fall-through not required.
  - Push when tx_valid && tx_ready. Pop only at frame start.
  - A push and a pop in the same cycle leaves fifo_count unchanged.
  - tx_ready = (fifo_count != FIFO_DEPTH). This is combinational from the count register.
  - No bypass: a word always passes through the FIFO.
- Baud counter:
  - Held at 0 in IDLE. Counts 0..CLKS_PER_BIT-1 in every other state.
  - baud_tick is asserted when the count equals CLKS_PER_BIT-1. The counter wraps to 0 on that cycle.
  - Each bit therefore lasts exactly CLKS_PER_BIT cycles.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
  - IDLE: if fifo_count != 0, pop the head word into the shift register, drive tx<=0 and go to START on the same edge. Otherwise hold tx=1.
    - Latency: a word accepted at edge E into an idle, empty block drives tx low after edge E+1.
  - START: on baud_tick, tx<=shift[0], shift right, bit_cnt<=1, go to DATA.
  - DATA: on baud_tick, if bit_cnt==DATA_BITS, go to PARITY (when present) or STOP with tx<=1. Otherwise tx<=shift[0], shift, bit_cnt+1.
  - PARITY: tx holds the parity bit for one bit period. On baud_tick, tx<=1 and go to STOP.
  - STOP: tx=1 for STOP_BITS bit periods, counted with bit_cnt. On the final baud_tick:
    - If the FIFO is non-empty, pop, drive tx<=0 and go to START (zero-gap back-to-back).
    - Otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with parity and 0 without.
- tx is a registered output and is glitch-free.
- tx_data is sampled only at push. Changes to tx_data afterwards do not affect queued words.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - The PARITY state is present.
  - Parity bit = ^data when PARITY_ODD=0, and ~^data when PARITY_ODD=1, computed over the DATA_BITS bits of the popped word.
  - The parity bit is captured at pop.
- Not defined:
  - No PARITY state and no parity logic is generated.
  - PARITY_ODD is ignored.
  - The frame goes DATA -> STOP directly.

Test Plan:
- Single word, CLKS_PER_BIT=4, 8N1, tx_data=0xA5 pushed once -> tx low one cycle after the push edge. Then tx shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, for 40 cycles total. baud_tick_o pulses 10 times. busy=0 afterwards.
- Burst, FIFO_DEPTH=4, tx_valid held for 6 cycles with values 0x01..0x06 -> exactly 5 words accepted, then tx_ready=0 with fifo_count=4. The five frames appear contiguously (200 cycles at CLKS_PER_BIT=4) with no extra high cycles between a stop bit and the next start bit.
- UART_TX_PARITY_EN with PARITY_ODD=0, data 0x07 -> parity bit 1. With PARITY_ODD=1 the parity bit is 0. Frame length is 11 bit periods.
- STOP_BITS=2, DATA_BITS=7, data 0x55 -> 7 data bits 1,0,1,0,1,0,1, then tx high for 8 cycles before the next start or idle.
- rst pulsed during data bit 3 with 2 words queued -> next cycle tx=1, fifo_count=0, busy=0, tx_ready=1. No frame follows.
- Push while full, simultaneous with a pop at frame start -> the word is refused because tx_ready was 0 that cycle. fifo_count drops by 1, and tx_ready returns high on the next cycle.
